// File: rtl/parity_sequencer.sv
// Odd-parity sequencer: walks a W-bit word three bits per cycle through a 3-input odd function.
// Optional feature: define PARITY_SEQUENCER_CNT_EN to add the 16-bit word_cnt result counter.
module parity_sequencer #(
   parameter  int GROUPS = 8,
   localparam int W      = 3 * GROUPS
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_parity,
   output logic         busy
`ifdef PARITY_SEQUENCER_CNT_EN
   ,
   output logic [15:0]  word_cnt
`endif
);

   localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          acc_q,   acc_d;
   logic          parity_q, parity_d;
   logic          grp_odd;

   // XOR of three bits is 1 exactly for one or three ones.
   assign grp_odd = ^shift_q[2:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         acc_q    <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         parity_q <= parity_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      parity_d = parity_q;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  shift_d = in_data;
                  acc_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               acc_d   = acc_q ^ grp_odd;
               shift_d = {3'b000, shift_q[W-1:3]};
               // Counter holds on the last group so it can never wrap.
               if (cnt_q == LAST_GRP) begin
                  parity_d = acc_q ^ grp_odd;
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q == S_RUN);
   assign out_valid  = (state_q == S_DONE);
   assign out_parity = parity_q;

`ifdef PARITY_SEQUENCER_CNT_EN
   logic [15:0] word_cnt_q;

   // Counts only real result handshakes; clr aborts DONE without a handshake.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         word_cnt_q <= '0;
      end else if ((state_q == S_DONE) && out_ready && !clr) begin
         word_cnt_q <= word_cnt_q + 16'd1;
      end
   end

   assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_parity_sequencer.sv
// Scoreboard bench for parity_sequencer: expected parities queued at acceptance, checked at handshake.
module tb_parity_sequencer;

   localparam int GROUPS = 8;
   localparam int W      = 3 * GROUPS;

   logic         clk       = 1'b0;
   logic         rstn      = 1'b0;
   logic         clr       = 1'b0;
   logic         in_valid  = 1'b0;
   logic [W-1:0] in_data   = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic         out_parity;
   logic         busy;
`ifdef PARITY_SEQUENCER_CNT_EN
   logic [15:0]  word_cnt;
`endif

   int   errors = 0;
   int   checks = 0;
   int   hs_cnt = 0;
   int   exp_wc = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   parity_sequencer #(.GROUPS(GROUPS)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .busy       (busy)
`ifdef PARITY_SEQUENCER_CNT_EN
      ,
      .word_cnt   (word_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Result monitor: a handshake happens on the next rising edge.
   always @(negedge clk) begin
      if (rstn && !clr && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_result", 1, 0);
         end else begin
            check("parity", out_parity, exp_q[0]);
            $display("xfer %0d parity=%0b expected=%0b", hs_cnt, out_parity, exp_q[0]);
            void'(exp_q.pop_front());
         end
         hs_cnt++;
      end
   end

   task automatic accept(input logic [W-1:0] d);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      exp_q.push_back(^d);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic run_word(input logic [W-1:0] d, input int hold);
      int lat;
      int rdy_low;
      out_ready = (hold == 0);
      accept(d);
      lat     = -1;
      rdy_low = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!in_ready) rdy_low++;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, 8);
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", out_valid, 1);
         check("hold_parity", out_parity, ^d);
         @(posedge clk);
         #1;
         if (h == hold - 1) out_ready = 1'b1;
         @(negedge clk);
         if (!in_ready) rdy_low++;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle_after", in_ready, 1);
      check("valid_drop", out_valid, 0);
      check("ready_low_cycles", rdy_low, 9 + hold);
      exp_wc++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ghost;
      int n;
      int hs_before;

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_parity", out_parity, 0);
`ifdef PARITY_SEQUENCER_CNT_EN
      check("rst_word_cnt", word_cnt, 0);
`endif
      @(posedge clk);
      #1 rstn = 1'b1;

      run_word(24'h000001, 0);
      run_word(24'hA5A5A5, 5);
      run_word(24'hFFFFFF, 0);
      run_word(24'h000007, 0);
      @(posedge clk);
      #1;
      check("hs_count", hs_cnt, 4);
`ifdef PARITY_SEQUENCER_CNT_EN
      check("word_cnt_4", word_cnt, exp_wc);
`endif

      // Reset in the middle of RUN: the word must vanish.
      out_ready = 1'b1;
      accept(24'h000001);
      repeat (4) @(posedge clk);
      #1;
      check("busy_mid_run", busy, 1);
      rstn = 1'b0;
      exp_q.delete();
      exp_wc = 0;
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_parity", out_parity, 0);
`ifdef PARITY_SEQUENCER_CNT_EN
      check("abort_word_cnt", word_cnt, 0);
`endif
      ghost = 0;
      repeat (12) begin
         @(negedge clk);
         ghost += int'(out_valid);
      end
      check("abort_no_result", ghost, 0);
      run_word(24'h000003, 0);

      // clr wins over in_valid in IDLE.
      @(posedge clk);
      #1;
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'h000001;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("clr_idle_ready", in_ready, 1);
      check("clr_idle_busy", busy, 0);
      ghost = 0;
      repeat (10) begin
         @(negedge clk);
         ghost += int'(out_valid);
      end
      check("clr_idle_no_result", ghost, 0);

      // clr in DONE discards the pending result.
      out_ready = 1'b0;
      accept(24'h000001);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("clr_done_reached", out_valid, 1);
      hs_before = hs_cnt;
      @(posedge clk);
      #1;
      clr       = 1'b1;
      out_ready = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      check("clr_done_valid", out_valid, 0);
      check("clr_done_ready", in_ready, 1);
      check("clr_done_no_hs", hs_cnt, hs_before);
`ifdef PARITY_SEQUENCER_CNT_EN
      check("clr_word_cnt", word_cnt, exp_wc);
`endif

      for (int k = 0; k < 6; k++) begin
         run_word(W'($urandom), $urandom_range(0, 2));
      end
`ifdef PARITY_SEQUENCER_CNT_EN
      check("word_cnt_final", word_cnt, exp_wc);
`endif

      @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
`ifdef PARITY_SEQUENCER_CNT_EN
      check("word_cnt_rst", word_cnt, 0);
`endif
      check("end_in_ready", in_ready, 1);
      check("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
